// File: rtl/cpu1_debug_ocimem_ctrl_pkg.sv
// Shared definitions for the OCI debug-memory controller: state encoding and
// the bit positions of the fields carried in the 38-bit jdo command payload.
package cpu1_debug_ocimem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_WR_REQ  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_REQ  = ST_RD_REQ,
        RD_WAIT = ST_RD_WAIT,
        WR_REQ  = ST_WR_REQ
    } state_t;

    localparam int JDO_RDNOW     = 37;
    localparam int JDO_CLROVR    = 36;
    localparam int JDO_AINC      = 35;
    localparam int JDO_WDATA_MSB = 34;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu1_debug_ocimem_ctrl.sv
// Turns decoded JTAG monitor commands into single-word debug-memory accesses
// and keeps the monitor address/data registers for the debug slave.
module cpu1_debug_ocimem_ctrl
    import cpu1_debug_ocimem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_rdvalid,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_busy,
    output logic              cmd_overrun
);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   mon_addr_r, mon_addr_s;
    logic [31:0]         mon_data_r, mon_data_s;
    logic [31:0]         wdata_r, wdata_s;
    logic                ainc_r, ainc_s;
    logic                overrun_r, overrun_s;
    logic                rd_r, wr_r, busy_r;
    logic                done_s;
    logic                any_pulse_s;

    // Next-state, register-update and overrun logic for the access FSM.
    always_comb begin
        state_s     = state_r;
        mon_addr_s  = mon_addr_r;
        mon_data_s  = mon_data_r;
        wdata_s     = wdata_r;
        ainc_s      = ainc_r;
        overrun_s   = overrun_r;
        done_s      = 1'b0;
        any_pulse_s = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

        case (state_r)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_addr_s = jdo[ADDR_W-1:0];
                    ainc_s     = jdo[JDO_AINC];
                    // A dropped lower-priority pulse beats clear_overrun.
                    if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                        overrun_s = 1'b1;
                    end else if (jdo[JDO_CLROVR]) begin
                        overrun_s = 1'b0;
                    end else begin
                        overrun_s = overrun_r;
                    end
                    if (jdo[JDO_RDNOW]) begin
                        state_s = RD_REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_s = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                    state_s = WR_REQ;
                    if (take_no_action_ocimem_a) begin
                        overrun_s = 1'b1;
                    end else begin
                        overrun_s = overrun_r;
                    end
                end else if (take_no_action_ocimem_a) begin
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (!mem_waitrequest) begin
                    if (mem_rdvalid) begin
                        mon_data_s = mem_rdata;
                        done_s     = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        state_s = RD_WAIT;
                    end
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (mem_rdvalid) begin
                    mon_data_s = mem_rdata;
                    done_s     = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (!mem_waitrequest) begin
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = WR_REQ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (done_s && ainc_r) begin
            mon_addr_s = mon_addr_r + ADDR_W'(1);
        end else begin
            mon_addr_s = mon_addr_s;
        end

        if ((state_r != IDLE) && any_pulse_s) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_s;
        end
    end

    // State and datapath registers; request strobes are decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            mon_addr_r <= '0;
            mon_data_r <= 32'd0;
            wdata_r    <= 32'd0;
            ainc_r     <= 1'b0;
            overrun_r  <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            mon_addr_r <= mon_addr_s;
            mon_data_r <= mon_data_s;
            wdata_r    <= wdata_s;
            ainc_r     <= ainc_s;
            overrun_r  <= overrun_s;
            rd_r       <= (state_s == RD_REQ);
            wr_r       <= (state_s == WR_REQ);
            busy_r     <= (state_s != IDLE);
        end
    end

    assign mem_addr     = mon_addr_r;
    assign MonAReg      = mon_addr_r;
    assign mem_rd       = rd_r;
    assign mem_wr       = wr_r;
    assign mem_wdata    = wdata_r;
    assign MonDReg      = mon_data_r;
    assign monitor_busy = busy_r;
    assign cmd_overrun  = overrun_r;

endmodule

// File: tb/tb_cpu1_debug_ocimem_ctrl.sv
// Self-checking bench: a behavioural debug memory answers requests and a
// scoreboard queue holds the accesses each command is expected to produce.
module tb_cpu1_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        take_a, take_b, take_na;
    logic [37:0] jdo;
    logic [7:0]  mem_addr;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_wdata;
    logic        mem_waitrequest;
    logic [31:0] mem_rdata;
    logic        mem_rdvalid;
    logic [31:0] MonDReg;
    logic [7:0]  MonAReg;
    logic        monitor_busy, cmd_overrun;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_model [256];
    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_cycles = 0;
    int          rd_lat = 1;
    int          rd_cycles = 0;
    int          rd_accepts = 0;
    logic        inject_rd = 1'b0;

    cpu1_debug_ocimem_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .take_action_ocimem_a(take_a), .take_action_ocimem_b(take_b),
        .take_no_action_ocimem_a(take_na), .jdo(jdo),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_waitrequest(mem_waitrequest), .mem_rdata(mem_rdata), .mem_rdvalid(mem_rdvalid),
        .MonDReg(MonDReg), .MonAReg(MonAReg),
        .monitor_busy(monitor_busy), .cmd_overrun(cmd_overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic rd, input logic clr, input logic ainc, input logic [7:0] a);
        return {rd, clr, ainc, 27'd0, a};
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    task automatic cmd(input logic a, input logic b, input logic na, input logic [37:0] d);
        @(posedge clk); #2;
        take_a = a; take_b = b; take_na = na; jdo = d;
        @(posedge clk); #2;
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!monitor_busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!ok) check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic accept_check();
        exp_t e;
        if (mem_wr) mem_model[mem_addr] = mem_wdata;
        else rd_accepts++;
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_access", {23'd0, mem_wr, mem_addr}, 32'hFFFFFFFF);
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_kind", {31'd0, mem_wr}, {31'd0, e.wr});
            check_eq("sb_addr", {24'd0, mem_addr}, {24'd0, e.addr});
            if (e.wr) check_eq("sb_wdata", mem_wdata, e.data);
        end
    endtask

    // Behavioural memory: programmable stall length and read latency.
    initial begin
        int  wcnt = 0;
        int  pcnt = 0;
        bit  pend = 1'b0;
        logic [7:0] paddr = 8'd0;
        mem_waitrequest = 1'b0; mem_rdvalid = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            mem_rdvalid = 1'b0;
            if (!reset_n) begin
                pend = 1'b0; wcnt = 0; mem_waitrequest = 1'b0;
            end else begin
                if (inject_rd) begin
                    mem_rdvalid = 1'b1; mem_rdata = 32'hBADBAD00; inject_rd = 1'b0;
                end
                if (pend) begin
                    if (pcnt == 0) begin
                        mem_rdvalid = 1'b1; mem_rdata = mem_model[paddr]; pend = 1'b0;
                    end else begin
                        pcnt--;
                    end
                end
                if (mem_rd) rd_cycles++;
                if (mem_rd || mem_wr) begin
                    if (wcnt < wait_cycles) begin
                        mem_waitrequest = 1'b1; wcnt++;
                    end else begin
                        mem_waitrequest = 1'b0; wcnt = 0;
                        accept_check();
                        if (mem_rd) begin
                            if (rd_lat == 0) begin
                                mem_rdvalid = 1'b1; mem_rdata = mem_model[mem_addr];
                            end else begin
                                pend = 1'b1; pcnt = rd_lat - 1; paddr = mem_addr;
                            end
                        end
                    end
                end else begin
                    mem_waitrequest = 1'b0;
                end
            end
        end
    end

    initial begin
        int rb;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'h5A000000 ^ (i * 32'h01010101);
        mem_model[16] = 32'hDEADBEEF;
        take_a = 1'b0; take_b = 1'b0; take_na = 1'b0; jdo = 38'd0;
        reset_n = 1'b0;
        #22 reset_n = 1'b1;
        @(posedge clk); #2;
        check_eq("rst_outputs", {mem_rd, mem_wr, monitor_busy, cmd_overrun}, 32'd0);
        check_eq("rst_addr", {24'd0, MonAReg}, 32'd0);
        check_eq("rst_mondreg", MonDReg, 32'd0);

        // Stalled read: 2 wait cycles, data 1 cycle after acceptance.
        wait_cycles = 2; rd_lat = 1; rd_cycles = 0;
        sb_q.push_back('{wr: 1'b0, addr: 8'h10, data: 32'hDEADBEEF});
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b0, 8'h10));
        check_eq("rd_timing", {30'd0, mem_rd, monitor_busy}, 32'd3);
        wait_idle();
        check_eq("rd_cycles", rd_cycles, 32'd3);
        check_eq("rd_data", MonDReg, 32'hDEADBEEF);
        check_eq("rd_addr_hold", {24'd0, MonAReg}, 32'h10);

        // Auto-increment writes wrapping past 0xFF.
        wait_cycles = 0; rb = rd_accepts;
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 1'b1, 8'hFE));
        check_eq("noread_busy", {31'd0, monitor_busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] d;
            d = 32'h11111111 * (i + 1);
            sb_q.push_back('{wr: 1'b1, addr: 8'(8'hFE + i), data: d});
            wait_cycles = i;
            cmd(1'b0, 1'b1, 1'b0, mk_b(d));
            wait_idle();
        end
        check_eq("wr_wrap_addr", {24'd0, MonAReg}, 32'h01);
        check_eq("wr_no_read", rd_accepts, rb);

        // Streaming reads with varied stall/latency, including same-cycle data.
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b0, 1'b1, 8'h20));
        for (int i = 0; i < 4; i++) begin
            wait_cycles = i % 2; rd_lat = i;
            sb_q.push_back('{wr: 1'b0, addr: 8'(8'h20 + i), data: 32'd0});
            cmd(1'b0, 1'b0, 1'b1, 38'd0);
            wait_idle();
            check_eq("stream_data", MonDReg, mem_model[8'h20 + i]);
        end
        check_eq("stream_addr", {24'd0, MonAReg}, 32'h24);
        check_eq("wdata_hold", mem_wdata, 32'h33333333);

        // Write pulse during an outstanding read is dropped and flagged.
        wait_cycles = 0; rd_lat = 5;
        sb_q.push_back('{wr: 1'b0, addr: 8'h30, data: 32'd0});
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b0, 8'h30));
        cmd(1'b0, 1'b1, 1'b0, mk_b(32'hCAFEF00D));
        wait_idle();
        check_eq("ovr_set", {31'd0, cmd_overrun}, 32'd1);
        check_eq("ovr_rd_data", MonDReg, mem_model[8'h30]);
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 1'b0, 8'h30));
        check_eq("ovr_clear", {31'd0, cmd_overrun}, 32'd0);

        // Simultaneous a+b: address load only; set beats clear_overrun.
        cmd(1'b1, 1'b1, 1'b0, mk_a(1'b0, 1'b0, 1'b0, 8'h40));
        check_eq("dual_busy", {31'd0, monitor_busy}, 32'd0);
        check_eq("dual_addr", {24'd0, MonAReg}, 32'h40);
        check_eq("dual_ovr", {31'd0, cmd_overrun}, 32'd1);
        cmd(1'b1, 1'b0, 1'b1, mk_a(1'b0, 1'b1, 1'b0, 8'h41));
        check_eq("set_beats_clr", {31'd0, cmd_overrun}, 32'd1);

        // Reset during RD_WAIT, late rdvalid after release.
        wait_cycles = 0; rd_lat = 99;
        sb_q.push_back('{wr: 1'b0, addr: 8'h50, data: 32'd0});
        cmd(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b0, 8'h50));
        @(posedge clk); #3;
        check_eq("pre_rst_busy", {30'd0, mem_rd, monitor_busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_rst", {30'd0, mem_rd, monitor_busy}, 32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        inject_rd = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_eq("late_rdvalid", MonDReg, 32'd0);
        check_eq("post_rst_idle", {29'd0, mem_rd, mem_wr, monitor_busy}, 32'd0);
        check_eq("post_rst_addr", {24'd0, MonAReg}, 32'd0);
        check_eq("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
